// File: rtl/i2c_wb_write_sequencer.sv
// Wishbone master that drives the iicmb_m_wb register sequence for one I2C write:
// CSR enable, Set Bus, Start, address, payload bytes, Stop, then reports a status code.
module i2c_wb_write_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [7:0]               req_bus_id,
    input  logic [6:0]               req_addr,
    input  logic [LEN_WIDTH-1:0]     req_len,
    input  logic                     data_valid,
    output logic                     data_ready,
    input  logic [7:0]               data_byte,
    output logic                     done,
    output logic [1:0]               status,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq,
    output logic [2:0]               dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);

    typedef enum logic [2:0] {
        S_INIT_CSR, S_IDLE, S_DPR_WR, S_CMD_WR, S_WAIT_IRQ, S_CMD_RD, S_DATA_WAIT, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        STEP_SETBUS, STEP_START, STEP_ADDR, STEP_DATA, STEP_STOP
    } step_t;

    state_t                   state_q, state_d;
    step_t                    step_q, step_d;
    logic                     cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
    logic                     req_ready_q, req_ready_d;
    logic                     data_ready_q, data_ready_d;
    logic                     done_q, done_d;
    logic [1:0]               status_q, status_d;
    logic [1:0]               err_q, err_d;
    logic [7:0]               dpr_q, dpr_d;
    logic [6:0]               addr_q, addr_d;
    logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]            tmo_q, tmo_d;

    logic [2:0] cmd_code;
    logic [1:0] rd_code;
    logic       rd_ok;
    logic       unused_dat;

    assign unused_dat = ^dat_i;

    always_comb begin
        case (step_q)
            STEP_SETBUS: cmd_code = 3'b110;
            STEP_START:  cmd_code = 3'b100;
            STEP_STOP:   cmd_code = 3'b101;
            default:     cmd_code = 3'b001;
        endcase
    end

    // DON wins outright; among failures AL outranks NAK, which outranks ERR.
    assign rd_ok   = dat_i[7];
    assign rd_code = dat_i[5] ? 2'b10 : (dat_i[6] ? 2'b01 : 2'b11);

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        req_ready_d  = req_ready_q;
        data_ready_d = data_ready_q;
        done_d       = 1'b0;
        status_d     = status_q;
        err_d        = err_q;
        dpr_d        = dpr_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;

        // Every access ends on ack; the next state then spends one idle cycle before launching.
        if (cyc_q && ack_i) begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            we_d  = 1'b0;
            adr_d = '0;
            dat_d = '0;
        end

        case (state_q)
            S_INIT_CSR: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b1;
                    adr_d = ADR_CSR;
                    dat_d = WB_DATA_WIDTH'(8'hC0);
                end else if (ack_i) begin
                    state_d     = S_IDLE;
                    req_ready_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    dpr_d       = req_bus_id;
                    addr_d      = req_addr;
                    cnt_d       = req_len;
                    err_d       = 2'b00;
                    step_d      = STEP_SETBUS;
                    state_d     = S_DPR_WR;
                end
            end
            S_DPR_WR: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b1;
                    adr_d = ADR_DPR;
                    dat_d = WB_DATA_WIDTH'(dpr_q);
                end else if (ack_i) begin
                    state_d = S_CMD_WR;
                end
            end
            S_CMD_WR: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b1;
                    adr_d = ADR_CMDR;
                    dat_d = WB_DATA_WIDTH'(cmd_code);
                end else if (ack_i) begin
                    state_d = S_WAIT_IRQ;
                    tmo_d   = '0;
                end
            end
            S_WAIT_IRQ: begin
                if (irq) begin
                    state_d = S_CMD_RD;
                end else if (tmo_q == TO_LAST) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    status_d = 2'b11;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_CMD_RD: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b0;
                    adr_d = ADR_CMDR;
                    dat_d = '0;
                end else if (ack_i) begin
                    if (step_q == STEP_STOP) begin
                        // A Stop issued to recover from an error reports the original error.
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        status_d = (err_q != 2'b00) ? err_q : (rd_ok ? 2'b00 : rd_code);
                    end else if (!rd_ok && rd_code == 2'b10) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        status_d = 2'b10;
                    end else if (!rd_ok) begin
                        err_d   = rd_code;
                        step_d  = STEP_STOP;
                        state_d = S_CMD_WR;
                    end else if (step_q == STEP_SETBUS) begin
                        step_d  = STEP_START;
                        state_d = S_CMD_WR;
                    end else if (step_q == STEP_START) begin
                        step_d  = STEP_ADDR;
                        dpr_d   = {addr_q, 1'b0};
                        state_d = S_DPR_WR;
                    end else if (cnt_q == '0) begin
                        step_d  = STEP_STOP;
                        state_d = S_CMD_WR;
                    end else begin
                        state_d      = S_DATA_WAIT;
                        data_ready_d = 1'b1;
                    end
                end
            end
            S_DATA_WAIT: begin
                if (data_valid && data_ready_q) begin
                    data_ready_d = 1'b0;
                    dpr_d        = data_byte;
                    cnt_d        = cnt_q - LEN_WIDTH'(1);
                    step_d       = STEP_DATA;
                    state_d      = S_DPR_WR;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = S_INIT_CSR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_INIT_CSR;
            step_q       <= STEP_SETBUS;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            req_ready_q  <= 1'b0;
            data_ready_q <= 1'b0;
            done_q       <= 1'b0;
            status_q     <= 2'b00;
            err_q        <= 2'b00;
            dpr_q        <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            req_ready_q  <= req_ready_d;
            data_ready_q <= data_ready_d;
            done_q       <= done_d;
            status_q     <= status_d;
            err_q        <= err_d;
            dpr_q        <= dpr_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign data_ready = data_ready_q;
    assign done       = done_q;
    assign status     = status_q;
    assign cyc_o      = cyc_q;
    assign stb_o      = stb_q;
    assign we_o       = we_q;
    assign adr_o      = adr_q;
    assign dat_o      = dat_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_i2c_wb_write_sequencer.sv
// Randomized bench: a controller responder acks/interrupts, a transaction-level model
// predicts the register access list, status, consumed bytes and timeout latency.
module tb_i2c_wb_write_sequencer;

    localparam int T = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_bus_id = 8'h00;
    logic [6:0] req_addr = 7'h00;
    logic [7:0] req_len = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic [7:0] data_byte = 8'h00;
    logic       done;
    logic [1:0] status;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i = 8'h00;
    logic       ack_i = 1'b0;
    logic       irq = 1'b0;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    i2c_wb_write_sequencer #(
        .WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .LEN_WIDTH(8), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_bus_id(req_bus_id),
        .req_addr(req_addr), .req_len(req_len),
        .data_valid(data_valid), .data_ready(data_ready), .data_byte(data_byte),
        .done(done), .status(status),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .irq(irq), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int cmd_ack_cyc = 0;
    int wait_cnt = 0;
    int irq_cd = -1;
    logic [7:0] pend_rsp = 8'h80;

    // Access encoding: {we, adr[1:0], data} with reads carrying data 0.
    logic [10:0] exp_q[$];
    // Controller response per CMDR write: bit8 = never interrupt, else CMDR read value.
    logic [8:0]  rsp_q[$];
    logic [8:0]  plan_q[$];
    logic [7:0]  bytes[$];
    logic [1:0]  exp_status;
    int          exp_consumed;
    bit          exp_to;
    logic [1:0]  last_status = 2'b00;
    int          idx;
    int          dr_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc_cnt++;

    // Controller responder and access monitor.
    always @(negedge clk) begin : responder
        logic [10:0] op;
        logic [8:0]  rv;
        if (!rst) begin
            ack_i = 1'b0; irq = 1'b0; irq_cd = -1; wait_cnt = 0;
        end else begin
            if (irq_cd > 0) begin
                irq_cd--;
                if (irq_cd == 0) begin irq = 1'b1; irq_cd = -1; end
            end
            if (ack_i) begin
                ack_i = 1'b0;
            end else if (cyc_o && stb_o) begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else begin
                    op = {we_o, adr_o, we_o ? dat_o : 8'h00};
                    if (exp_q.size() == 0) check_eq("wb_unexpected", op, 11'h7ff);
                    else check_eq("wb_op", op, exp_q.pop_front());
                    if (we_o && adr_o == 2'd2) begin
                        rv = (rsp_q.size() != 0) ? rsp_q.pop_front() : 9'h080;
                        cmd_ack_cyc = cyc_cnt + 1;
                        if (!rv[8]) begin pend_rsp = rv[7:0]; irq_cd = $urandom_range(1, 4); end
                    end
                    if (!we_o && adr_o == 2'd2) begin dat_i = pend_rsp; irq = 1'b0; end
                    ack_i = 1'b1;
                    wait_cnt = $urandom_range(0, 2);
                end
            end
        end
    end

    function automatic logic [8:0] plan_at(input int k);
        return (k < plan_q.size()) ? plan_q[k] : 9'h080;
    endfunction

    function automatic logic [1:0] decode(input logic [7:0] v);
        return v[5] ? 2'd2 : (v[6] ? 2'd1 : 2'd3);
    endfunction

    // Transaction-level prediction: command list SetBus, Start, Addr, data..., then Stop.
    task automatic model_txn(input logic [7:0] bus, input logic [6:0] a, input int len);
        int k = 0;
        logic [8:0] rv;
        bit failed = 0;
        bit ended = 0;
        exp_status = 2'd0; exp_consumed = 0; exp_to = 0;
        for (int c = 0; c < 3 + len && !failed; c++) begin
            if (c == 0) exp_q.push_back({3'b101, bus});
            else if (c == 2) exp_q.push_back({3'b101, a, 1'b0});
            else if (c >= 3) begin exp_q.push_back({3'b101, bytes[c-3]}); exp_consumed++; end
            exp_q.push_back({3'b110, 5'd0, (c == 0) ? 3'b110 : ((c == 1) ? 3'b100 : 3'b001)});
            rv = plan_at(k); k++;
            if (rv[8]) begin
                exp_status = 2'd3; exp_to = 1; failed = 1; ended = 1;
            end else begin
                exp_q.push_back({3'b010, 8'h00});
                if (!rv[7]) begin
                    failed = 1;
                    exp_status = decode(rv[7:0]);
                    if (exp_status == 2'd2) ended = 1;
                end
            end
        end
        if (!ended) begin
            exp_q.push_back({3'b110, 8'h05});
            rv = plan_at(k);
            if (rv[8]) begin
                exp_status = 2'd3; exp_to = 1;
            end else begin
                exp_q.push_back({3'b010, 8'h00});
                if (exp_status == 2'd0 && !rv[7]) exp_status = decode(rv[7:0]);
            end
        end
    endtask

    task automatic tick_feed(input int len);
        @(negedge clk);
        if (data_ready) dr_seen++;
        if (data_valid) begin
            idx++;
            data_valid = 1'b0;
        end else if (data_ready && $urandom_range(0, 1) == 1) begin
            data_valid = 1'b1;
            data_byte = (idx < len) ? bytes[idx] : 8'hEE;
        end
    endtask

    task automatic issue_req(input logic [7:0] bus, input logic [6:0] a, input int len);
        int n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        check_eq("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_bus_id = bus; req_addr = a; req_len = len[7:0];
        @(negedge clk);
        req_valid = 1'b0;
        req_bus_id = 8'($urandom); req_addr = 7'($urandom); req_len = 8'($urandom);
        check_eq("req_ready_drop", req_ready, 0);
    endtask

    task automatic prep_txn(input logic [7:0] bus, input logic [6:0] a, input int len,
                            input logic [7:0] b0);
        bytes.delete();
        for (int i = 0; i < len; i++) bytes.push_back((i == 0) ? b0 : 8'($urandom));
        exp_q.delete();
        model_txn(bus, a, len);
        rsp_q = plan_q;
        idx = 0; dr_seen = 0;
    endtask

    task automatic run_txn(input string tag, input logic [7:0] bus, input logic [6:0] a,
                           input int len, input logic [7:0] b0);
        int n = 0;
        bit got = 0;
        int done_cyc = 0;
        prep_txn(bus, a, len, b0);
        check_eq({tag, "_status_hold"}, status, last_status);
        issue_req(bus, a, len);
        while (!got && n < 3000) begin
            tick_feed(len);
            n++;
            if (done) begin got = 1; done_cyc = cyc_cnt; end
        end
        check_eq({tag, "_done"}, got, 1);
        check_eq({tag, "_status"}, status, exp_status);
        check_eq({tag, "_consumed"}, idx, exp_consumed);
        if (len == 0) check_eq({tag, "_probe_no_ready"}, dr_seen, 0);
        if (exp_to) check_eq({tag, "_timeout_lat"}, done_cyc - cmd_ack_cyc, T);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, done, 0);
        check_eq({tag, "_wb_left"}, exp_q.size(), 0);
        last_status = exp_status;
    endtask

    task automatic do_reset();
        int n = 0;
        int busy = 0;
        rst = 1'b0; req_valid = 1'b0; data_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_outputs", {cyc_o, stb_o, we_o, adr_o, dat_o, req_ready, data_ready, done, status},
                 0);
        exp_q.delete(); rsp_q.delete();
        exp_q.push_back({3'b100, 8'hC0});
        rst = 1'b1;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        check_eq("init_req_ready", req_ready, 1);
        check_eq("init_csr_seen", exp_q.size(), 0);
        repeat (10) begin @(negedge clk); if (cyc_o) busy++; end
        check_eq("idle_no_wb", busy, 0);
        last_status = 2'b00;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] bad_tab[6];
        int n;
        bad_tab = '{9'h040, 9'h020, 9'h010, 9'h060, 9'h050, 9'h100};

        do_reset();

        plan_q = '{};
        run_txn("basic", 8'h05, 7'h22, 1, 8'h78);
        plan_q = '{9'h080, 9'h080, 9'h040};
        run_txn("probe_nak", 8'h01, 7'h50, 0, 8'h00);
        plan_q = '{9'h080, 9'h020};
        run_txn("al_start", 8'h02, 7'h11, 2, 8'h33);
        plan_q = '{9'h100};
        run_txn("timeout", 8'h03, 7'h7f, 1, 8'h44);
        plan_q = '{9'h080, 9'h080, 9'h080, 9'h080, 9'h010};
        run_txn("err_data", 8'h04, 7'h01, 3, 8'h9a);
        plan_q = '{9'h080, 9'h080, 9'h080, 9'h040};
        run_txn("stop_nak", 8'h06, 7'h2a, 0, 8'h00);
        plan_q = '{9'h080, 9'h080, 9'h080, 9'h080, 9'h060};
        run_txn("stop_al_nak", 8'h07, 7'h3c, 1, 8'hff);
        plan_q = '{9'h080, 9'h080, 9'h080, 9'h080, 9'h040, 9'h020};
        run_txn("nak_then_stop_al", 8'h08, 7'h45, 2, 8'h00);

        for (int i = 0; i < 25; i++) begin
            int len = $urandom_range(0, 3);
            plan_q = '{};
            if ($urandom_range(0, 5) > 2) begin
                int pos = $urandom_range(0, 3 + len);
                for (int k = 0; k < pos; k++) plan_q.push_back(9'h080);
                plan_q.push_back(bad_tab[$urandom_range(0, 5)]);
            end
            run_txn("rand", 8'($urandom), 7'($urandom), len, 8'($urandom));
        end

        // Reset in the middle of a payload byte write.
        plan_q = '{};
        prep_txn(8'h09, 7'h12, 3, 8'h5a);
        issue_req(8'h09, 7'h12, 3);
        n = 0;
        while (!(idx >= 1 && cyc_o) && n < 1000) begin tick_feed(3); n++; end
        check_eq("midop_cyc_high", cyc_o, 1);
        #1 rst = 1'b0;
        #1 check_eq("midop_rst_async", {cyc_o, stb_o}, 2'b00);
        do_reset();
        plan_q = '{};
        run_txn("after_rst", 8'h0a, 7'h66, 2, 8'h81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_wb_write_sequencer.md
Name: i2c_wb_write_sequencer

Overview:
Hardware Wishbone master that sits directly upstream of the I2C multi-bus controller (iicmb_m_wb) and replaces the bench's manual register pokes. It accepts a high-level write request (bus ID, 7-bit slave address, byte count), then streams payload bytes. It drives the full CSR/DPR/CMDR sequence: enable, Set Bus, Start, address byte, data bytes, Stop. It waits on irq after each command, reads CMDR to clear it, and reports a status code.

Parameters:
WB_ADDR_WIDTH, 2, Wishbone address width (CSR=0, DPR=1, CMDR=2)
WB_DATA_WIDTH, 8, Wishbone data width
LEN_WIDTH, 8, width of the byte-count field
TIMEOUT_CYCLES, 100000, clk cycles allowed waiting for irq before ERR

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  sequencer idle and able to accept a request
req_bus_id  in  8  I2C bus ID written to DPR before Set Bus
req_addr  in  7  slave address; sent as {req_addr,1'b0}
req_len  in  LEN_WIDTH  number of payload bytes (0 = address-only probe)
data_valid  in  1  payload byte valid
data_ready  out  1  sequencer wants the next byte
data_byte  in  8  payload byte
done  out  1  one-cycle pulse at end of a request
status  out  2  00 OK, 01 NAK, 10 ARB_LOST, 11 ERR/timeout; valid with done, held until next done
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
we_o  out  1  Wishbone write enable
adr_o  out  WB_ADDR_WIDTH  register address
dat_o  out  WB_DATA_WIDTH  write data
dat_i  in  WB_DATA_WIDTH  read data
ack_i  in  1  Wishbone acknowledge
irq  in  1  controller interrupt

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. While rst=0, all outputs are 0, status=00, FSM=INIT_CSR. Reset mid-operation aborts immediately: cyc_o/stb_o drop the same instant and the request is lost.
- Wishbone bus cycle: cyc_o, stb_o, we_o, adr_o and dat_o are registered and held stable until the first clk edge with ack_i=1. They deassert on the following cycle. One access at a time; no back-to-back cycles, with at least one idle cycle between accesses.
- INIT_CSR: first state after reset. Writes CSR=8'hC0 (enable + interrupt enable) once, then goes to IDLE.
- IDLE: req_ready=1. On req_valid, latch bus_id, addr and len; req_ready drops next cycle.
- Command step primitive: optional DPR write, then CMDR write with the cmd code, then WAIT_IRQ, then a CMDR read on irq=1.
  - WAIT_IRQ counts cycles. On reaching TIMEOUT_CYCLES it skips the read and ends with status 11 (no Stop).
  - CMDR read decode: bit7 DON means success. Otherwise bit6 NAK gives 01, bit5 AL gives 10, bit4 ERR gives 11. Priority is AL > NAK > ERR.
- Command codes: Set Bus=3'b110, Start=3'b100, Write=3'b001, Stop=3'b101. Upper CMDR bits are written 0.
- Sequence: SETBUS (DPR=bus_id), START, ADDR (DPR={addr,0}, Write), then len data bytes, then STOP, then DONE with status 00.
- Data fetch: in DATA_WAIT, data_ready=1. A byte is accepted on data_valid&&data_ready, data_ready drops the next cycle, and the byte is written to DPR and then Write is issued. A decrementing byte counter reaching 0 goes to STOP. len=0 goes from ADDR straight to STOP.
- Error handling:
  - NAK or ERR on SETBUS/START/ADDR/DATA issues STOP. Stop's own status is ignored, and the original status is reported.
  - AL skips STOP.
  - Failure on STOP itself reports its decoded status.
  - Unconsumed payload bytes are not drained; data_ready stays 0 and the upstream must flush.
- DONE: done=1 for exactly one cycle, status updated the same cycle, then IDLE. req_ready may rise the cycle after done.
- A req_valid asserted during done is not accepted until IDLE. req_* changes while busy are ignored.

Test Plan:
- Reset, then no request → exactly one Wishbone write, adr=0 dat=8'hC0, then req_ready=1; cyc_o=0 thereafter.
- Request bus_id=5, addr=7'h22, len=1, data 8'h78, with the controller model ACKing all → WB write order: DPR=05, CMDR=06, rd CMDR, CMDR=04, rd, DPR=44, CMDR=01, rd, DPR=78, CMDR=01, rd, CMDR=05, rd; done pulse, status=00.
- len=0 probe, addr byte returns CMDR=8'h40 (NAK) → Stop CMDR=05 issued, data_ready never asserted, status=01.
- Arbitration lost on Start (CMDR read 8'h20) → no Stop write, done with status=10.
- irq never asserted after Set Bus → done exactly TIMEOUT_CYCLES cycles after entering WAIT_IRQ, status=11, no further WB access.
- rst pulled low mid-data-byte with cyc_o=1 → cyc_o/stb_o low immediately. After release: CSR write C0 again, then req_ready=1.
